// File: rtl/lsu_byte_sequencer_pkg.sv
// rtl/lsu_byte_sequencer_pkg.sv - shared types, funct3 codes, size decode and load extension for the byte-serial LSU
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    // Access size in bytes; only funct3[1:0] matters, the sign bit is handled by lsu_ext.
    function automatic logic [3:0] lsu_size(input logic [2:0] f3);
        logic [3:0] n;
        case (f3)
            F3_B, F3_BU: n = 4'd1;
            F3_H, F3_HU: n = 4'd2;
            F3_W, F3_WU: n = 4'd4;
            F3_D:        n = 4'd8;
            default:     n = 4'd8;
        endcase
        return n;
    endfunction

    // Sign-extend from bit 8N-1 when funct3[2]=0, zero-extend when funct3[2]=1.
    function automatic logic [63:0] lsu_ext(input logic [63:0] d, input logic [2:0] f3);
        logic [63:0] r;
        case (f3[1:0])
            2'd0:    r = {{56{d[7]  & ~f3[2]}}, d[7:0]};
            2'd1:    r = {{48{d[15] & ~f3[2]}}, d[15:0]};
            2'd2:    r = {{32{d[31] & ~f3[2]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// rtl/lsu_byte_sequencer_if.sv - request/response and byte-memory bus bundle for the LSU
interface lsu_byte_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int XLEN   = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    // LSU view: consumes requests and memory read data, drives everything else.
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    // Core plus memory view.
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_byte_sequencer_extend.sv
// rtl/lsu_byte_sequencer_extend.sv - combinational sign/zero extension of assembled load bytes
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_data
);

    // Pure wrapper around the package helper so the top stays datapath-free here.
    always_comb begin
        o_data = lsu_ext(i_data, i_funct3);
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// rtl/lsu_byte_sequencer.sv - byte-serial RV64 load/store sequencer; LSU_MISALIGN_TRAP_EN makes misaligned accesses fault
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              reset,
    lsu_byte_sequencer_if.slave bus
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [63:0]       r_data;
    logic              r_err;
    logic [2:0]        r_count;
    logic [2:0]        r_last;

    logic [3:0]        w_size;
    logic [XLEN:0]     w_end;
    logic              w_range_err;
    logic              w_f3_err;
    logic              w_mis_err;
    logic              w_err;
    logic              w_accept;
    logic [63:0]       w_ext;

    // Accept-time decode: size, last byte address (one extra bit so the top never wraps) and faults.
    always_comb begin
        w_size      = lsu_size(bus.req_funct3);
        w_end       = {1'b0, bus.req_addr} + (XLEN+1)'(w_size) - (XLEN+1)'(1);
        w_range_err = w_end > (XLEN+1)'(2**ADDR_W - 1);
        w_f3_err    = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        w_mis_err   = (bus.req_addr[2:0] & (w_size[2:0] - 3'd1)) != 3'd0;
`else
        w_mis_err   = 1'b0;
`endif
        w_err       = w_range_err | w_f3_err | w_mis_err;
        w_accept    = bus.req_valid && (r_state == IDLE);
    end

    lsu_extend u_extend (
        .i_data   (r_data),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus all bus outputs, decoded from registered state only so they hold all cycle.
    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'h00;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_err ? RESP : XFER;
                end
            end
            XFER: begin
                bus.mem_addr = r_addr + ADDR_W'(r_count);
                bus.mem_we   = r_write;
                bus.mem_re   = !r_write;
                if (r_write) begin
                    bus.mem_wdata = r_wdata[{r_count, 3'b000} +: 8];
                end
                if (r_count == r_last) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = r_err;
                if (!r_err && !r_write) begin
                    bus.rsp_rdata = w_ext;
                end
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch at accept, then byte counter and load-lane capture during XFER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
            r_count  <= 3'd0;
            r_last   <= 3'd0;
        end else if (w_accept) begin
            r_write  <= bus.req_write;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr[ADDR_W-1:0];
            r_wdata  <= bus.req_wdata;
            r_data   <= '0;
            r_err    <= w_err;
            r_count  <= 3'd0;
            r_last   <= 3'(w_size - 4'd1);
        end else if (r_state == XFER) begin
            if (!r_write) begin
                r_data[{r_count, 3'b000} +: 8] <= bus.mem_rdata;
            end
            r_count <= r_count + 3'd1;
        end
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb/tb_lsu_byte_sequencer.sv - directed self-checking bench for lsu_byte_sequencer
module tb_lsu_byte_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   n_we;
    int   n_re;
    logic [5:0] last_re_addr;
    logic [7:0] mem [64] = '{default: 8'h00};

    lsu_byte_sequencer_if #(.ADDR_W(6), .XLEN(64)) bus ();

    lsu_byte_sequencer #(.ADDR_W(6), .XLEN(64)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Byte memory writes on the falling edge; also counts strobes.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            n_we <= n_we + 1;
        end
        if (bus.mem_re) begin
            n_re <= n_re + 1;
            last_re_addr <= bus.mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the response, check data/err/latency.
    task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err, input int exp_lat,
                        output int dwe, output int dre);
        int we0, re0, lat;
        logic [63:0] rd;
        logic er;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        we0 = n_we;
        re0 = n_re;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = i;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
                break;
            end
        end
        dwe = n_we - we0;
        dre = n_re - re0;
        chk({tag, ".lat"},   64'(lat), 64'(exp_lat));
        chk({tag, ".err"},   64'(er),  64'(exp_err));
        chk({tag, ".rdata"}, rd,       exp_rd);
    endtask

    initial begin
        int dwe, dre;
        logic [63:0] v;
        n_cmp = 0;
        n_bad = 0;
        n_we  = 0;
        n_re  = 0;
        last_re_addr = '0;
        rst_n = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst.req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst.rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("rst.rsp_rdata", bus.rsp_rdata,      64'd0);
        chk("rst.mem_we",    64'(bus.mem_we),    64'd0);
        chk("rst.mem_re",    64'(bus.mem_re),    64'd0);
        chk("rst.mem_addr",  64'(bus.mem_addr),  64'd0);
        chk("rst.mem_wdata", 64'(bus.mem_wdata), 64'd0);
        rst_n = 1'b1;

        // sb 40 then lbu 40
        xact("sb40", 1'b1, 3'd0, 64'd40, 64'h08, 64'd0, 1'b0, 2, dwe, dre);
        chk("sb40.nwe", 64'(dwe), 64'd1);
        chk("sb40.mem", 64'(mem[40]), 64'h08);
        xact("lbu40", 1'b0, 3'd4, 64'd40, 64'd0, 64'h8, 1'b0, 2, dwe, dre);
        chk("lbu40.nre", 64'(dre), 64'd1);
        chk("lbu40.addr", 64'(last_re_addr), 64'd40);

        // sd 8 / ld 8
        xact("sd8", 1'b1, 3'd3, 64'd8, 64'h8877665544332211, 64'd0, 1'b0, 9, dwe, dre);
        chk("sd8.nwe", 64'(dwe), 64'd8);
        for (int i = 0; i < 8; i++) begin
            v = 64'h11 * 64'(i + 1);
            chk("sd8.byte", 64'(mem[8 + i]), v);
        end
        xact("ld8", 1'b0, 3'd3, 64'd8, 64'd0, 64'h8877665544332211, 1'b0, 9, dwe, dre);
        chk("ld8.nre", 64'(dre), 64'd8);

        // halfword sign / zero extension
        xact("sh0", 1'b1, 3'd1, 64'd0, 64'hFF80, 64'd0, 1'b0, 3, dwe, dre);
        xact("lh0", 1'b0, 3'd1, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0, 3, dwe, dre);
        xact("lhu0", 1'b0, 3'd5, 64'd0, 64'd0, 64'h000000000000FF80, 1'b0, 3, dwe, dre);

        // top-of-memory boundary: last legal doubleword
        xact("sd56", 1'b1, 3'd3, 64'd56, 64'h0123456789ABCDEF, 64'd0, 1'b0, 9, dwe, dre);
        xact("ld56", 1'b0, 3'd3, 64'd56, 64'd0, 64'h0123456789ABCDEF, 1'b0, 9, dwe, dre);

        // faults: no memory cycles, response one cycle after accept
        xact("ld60", 1'b0, 3'd3, 64'd60, 64'd0, 64'd0, 1'b1, 1, dwe, dre);
        chk("ld60.nmem", 64'(dwe + dre), 64'd0);
        xact("ld57", 1'b0, 3'd3, 64'd57, 64'd0, 64'd0, 1'b1, 1, dwe, dre);
        xact("ldwrap", 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFF9, 64'd0, 64'd0, 1'b1, 1, dwe, dre);
        chk("ldwrap.nmem", 64'(dwe + dre), 64'd0);
        xact("st_f3_4", 1'b1, 3'd4, 64'd32, 64'hAA, 64'd0, 1'b1, 1, dwe, dre);
        chk("st_f3_4.nwe", 64'(dwe), 64'd0);
        xact("ld_f3_7", 1'b0, 3'd7, 64'd32, 64'd0, 64'd0, 1'b1, 1, dwe, dre);

        // misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
        xact("sw2", 1'b1, 3'd2, 64'd2, 64'h87654321, 64'd0, 1'b1, 1, dwe, dre);
        xact("lw2", 1'b0, 3'd2, 64'd2, 64'd0, 64'd0, 1'b1, 1, dwe, dre);
        chk("lw2.nre", 64'(dre), 64'd0);
`else
        xact("sw2", 1'b1, 3'd2, 64'd2, 64'h87654321, 64'd0, 1'b0, 5, dwe, dre);
        xact("lw2", 1'b0, 3'd2, 64'd2, 64'd0, 64'hFFFFFFFF87654321, 1'b0, 5, dwe, dre);
        chk("lw2.nre", 64'(dre), 64'd4);
        chk("lw2.b0", 64'(mem[0]), 64'h80);
`endif

        // reset during the fourth byte of sd 16
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd3;
        bus.req_addr   = 64'd16;
        bus.req_wdata  = 64'hF0E0D0C0B0A09080;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstx.mem_we", 64'(bus.mem_we), 64'd0);
        chk("rstx.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstx.req_ready", 64'(bus.req_ready), 64'd1);
        chk("rstx.rsp_after", 64'(bus.rsp_valid), 64'd0);
        chk("rstx.b16", 64'(mem[16]), 64'h80);
        chk("rstx.b17", 64'(mem[17]), 64'h90);
        chk("rstx.b18", 64'(mem[18]), 64'hA0);
        for (int i = 19; i < 24; i++) begin
            chk("rstx.untouched", 64'(mem[i]), 64'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
